// File: rtl/toothless_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : toothless_muldiv                                                 |
// | Purpose : Iterative RV32M/RV64M multiply/divide unit. Radix-2 shift-add    |
// |           multiply and restoring divide, one bit per cycle, with early     |
// |           completion for divide-by-zero and signed overflow.               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module toothless_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0]   ONE      = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE2     = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide)
  logic [XLEN-1:0]   opb_q, opb_d;
  // Multiply: {partial product high, multiplier}; divide: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_by_zero, div_ovf;

  logic [XLEN:0]     mul_sum, div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, div_sel, final_res;
  logic [2*XLEN-1:0] step, full_neg;

  // Request decode: operand signedness, magnitudes and early-completion cases
  always_comb begin
    a_signed    = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                  (op_i == OP_DIV)  || (op_i == OP_REM);
    b_signed    = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg       = a_signed & a_i[XLEN-1];
    b_neg       = b_signed & b_i[XLEN-1];
    a_mag       = a_neg ? (~a_i + ONE) : a_i;
    b_mag       = b_neg ? (~b_i + ONE) : b_i;
    div_by_zero = op_i[2] && (b_i == '0);
    div_ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                  (a_i == INT_MIN) && (b_i == '1);
  end

  // One iteration of the datapath plus sign-corrected final result selection
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                ({(XLEN+1){prod_q[0]}} & {1'b0, opb_q});
    div_trial = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge    = (div_trial >= {1'b0, opb_q});
    // When div_ge holds, the difference is below the divisor and fits XLEN bits
    div_diff  = div_trial[XLEN-1:0] - opb_q;
    if (op_q[2]) begin
      step = {(div_ge ? div_diff : div_trial[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};
    end else begin
      step = {mul_sum, prod_q[XLEN-1:1]};
    end
    full_neg = ~step + ONE2;
    div_sel  = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    if (op_q[2]) begin
      final_res = neg_q ? (~div_sel + ONE) : div_sel;
    end else if (op_q[1:0] == 2'b00) begin
      final_res = neg_q ? full_neg[XLEN-1:0] : step[XLEN-1:0];
    end else begin
      final_res = neg_q ? full_neg[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush overrides accept and the output handshake
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          op_d   = op_i;
          cnt_d  = '0;
          // Remainder follows the dividend sign; everything else is the sign product
          neg_d  = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
          opb_d  = op_i[2] ? b_mag : a_mag;
          prod_d = {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
          if (div_by_zero) begin
            result_d = op_i[1] ? a_i : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = op_i[1] ? '0 : a_i;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        prod_d = step;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          result_d = final_res;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule
`default_nettype wire
